// File: rtl/alu_cmd_seq_pkg.sv
// Shared definitions for the ALU command sequencer: opcodes, header field
// positions and FSM state encodings.
package alu_cmd_seq_pkg;

    localparam logic [1:0] OP_SRA = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b10;
    localparam logic [1:0] OP_ADD = 2'b11;

    // Header nibble layout: [3:2] opcode, [1:0] shift amount
    localparam int HDR_OP_MSB = 3;
    localparam int HDR_OP_LSB = 2;
    localparam int HDR_C_MSB  = 1;
    localparam int HDR_C_LSB  = 0;

    localparam int COUNT_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GET_A = 3'd1,
        ST_GET_B = 3'd2,
        ST_EXEC  = 3'd3,
        ST_HOLD  = 3'd4
    } seqState_t;

    // Only SUB and ADD carry a B operand nibble.
    function automatic logic needsOperandB(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/alu_seq_timeout.sv
// Idle-cycle counter for partially received commands; expire fires on the
// edge that would bring the idle count up to ABORT_CYCLES.
module alu_seq_timeout
    import alu_cmd_seq_pkg::*;
#(
    parameter int unsigned ABORT_CYCLES = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    logic [COUNT_W-1:0] idleCount;

    assign expire = enable && !clear && (idleCount == COUNT_W'(ABORT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            idleCount <= '0;
        end else if (clear || expire) begin
            idleCount <= '0;
        end else if (enable) begin
            idleCount <= idleCount + 1'b1;
        end
    end

endmodule

// File: rtl/alu_cmd_seq.sv
// Nibble-serial command sequencer feeding the 4-bit ALU and presenting its
// result over a valid/ready handshake, with idle-timeout abort.
module alu_cmd_seq
    import alu_cmd_seq_pkg::*;
#(
    parameter int unsigned ABORT_CYCLES = 15
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    input  logic [3:0]   in_data,
    output logic         in_ready,
    output logic [3:0]   alu_a,
    output logic [3:0]   alu_b,
    output logic [1:0]   alu_c,
    output logic [1:0]   alu_op,
    input  logic [4:0]   alu_ans,
    output logic         out_valid,
    output logic [4:0]   out_data,
    output logic [1:0]   out_op,
    input  logic         out_ready,
    output logic [7:0]   cmd_count,
    output logic         abort
);

    seqState_t state;
    seqState_t nextState;

    logic [3:0]         aluAReg;
    logic [3:0]         aluBReg;
    logic [1:0]         aluCReg;
    logic [1:0]         aluOpReg;
    logic               outValidReg;
    logic [4:0]         outDataReg;
    logic [1:0]         outOpReg;
    logic [COUNT_W-1:0] cmdCountReg;
    logic               abortReg;

    logic inReady;
    logic transfer;
    logic inGetState;
    logic expire;
    logic idleClear;
    logic idleEnable;

    always_comb begin
        inReady    = 1'b0;
        inGetState = 1'b0;
        case (state)
            ST_IDLE:           inReady = 1'b1;
            ST_GET_A, ST_GET_B: begin
                inReady    = 1'b1;
                inGetState = 1'b1;
            end
            default:           inReady = 1'b0;
        endcase
    end

    assign transfer   = in_valid && inReady;
    assign idleEnable = inGetState && !in_valid;
    // Counter restarts on any accepted nibble and whenever no operand is pending
    assign idleClear  = transfer || !inGetState;

    alu_seq_timeout #(
        .ABORT_CYCLES(ABORT_CYCLES)
    ) uTimeout (
        .clk    (clk),
        .reset  (reset),
        .clear  (idleClear),
        .enable (idleEnable),
        .expire (expire)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            ST_IDLE: begin
                if (transfer) nextState = ST_GET_A;
            end
            ST_GET_A: begin
                if (transfer) begin
                    nextState = needsOperandB(aluOpReg) ? ST_GET_B : ST_EXEC;
                end else if (expire) begin
                    nextState = ST_IDLE;
                end
            end
            ST_GET_B: begin
                if (transfer)    nextState = ST_EXEC;
                else if (expire) nextState = ST_IDLE;
            end
            ST_EXEC: nextState = ST_HOLD;
            ST_HOLD: begin
                if (out_ready) nextState = ST_IDLE;
            end
            default: nextState = ST_IDLE;
        endcase
    end

    // ALU operand registers change only on transfers, abort or reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            aluAReg     <= '0;
            aluBReg     <= '0;
            aluCReg     <= '0;
            aluOpReg    <= '0;
            outValidReg <= 1'b0;
            outDataReg  <= '0;
            outOpReg    <= '0;
            cmdCountReg <= '0;
            abortReg    <= 1'b0;
        end else begin
            abortReg <= expire;
            case (state)
                ST_IDLE: begin
                    if (transfer) begin
                        aluOpReg <= in_data[HDR_OP_MSB:HDR_OP_LSB];
                        aluCReg  <= in_data[HDR_C_MSB:HDR_C_LSB];
                        aluBReg  <= '0;
                    end
                end
                ST_GET_A, ST_GET_B: begin
                    if (transfer) begin
                        if (state == ST_GET_A) aluAReg <= in_data;
                        else                   aluBReg <= in_data;
                    end else if (expire) begin
                        aluAReg  <= '0;
                        aluBReg  <= '0;
                        aluCReg  <= '0;
                        aluOpReg <= '0;
                    end
                end
                ST_EXEC: begin
                    outDataReg  <= alu_ans;
                    outOpReg    <= aluOpReg;
                    outValidReg <= 1'b1;
                    cmdCountReg <= cmdCountReg + 1'b1;
                end
                ST_HOLD: begin
                    if (out_ready) outValidReg <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = inReady;
    assign alu_a     = aluAReg;
    assign alu_b     = aluBReg;
    assign alu_c     = aluCReg;
    assign alu_op    = aluOpReg;
    assign out_valid = outValidReg;
    assign out_data  = outDataReg;
    assign out_op    = outOpReg;
    assign cmd_count = cmdCountReg;
    assign abort     = abortReg;

endmodule

// File: tb/tb_alu_cmd_seq.sv
// Directed bench for alu_cmd_seq with a behavioural 4-bit ALU model
// closing the loop between alu_* and alu_ans.
module tb_alu_cmd_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [3:0] in_data;
    logic       in_ready;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [1:0] alu_c;
    logic [1:0] alu_op;
    logic [4:0] alu_ans;
    logic       out_valid;
    logic [4:0] out_data;
    logic [1:0] out_op;
    logic       out_ready;
    logic [7:0] cmd_count;
    logic       abort;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    alu_cmd_seq #(.ABORT_CYCLES(15)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_c     (alu_c),
        .alu_op    (alu_op),
        .alu_ans   (alu_ans),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_op    (out_op),
        .out_ready (out_ready),
        .cmd_count (cmd_count),
        .abort     (abort)
    );

    // ALU model: 5-bit two's-complement add/sub, shifts on the 4-bit A
    always_comb begin
        alu_ans = '0;
        case (alu_op)
            2'b00: alu_ans = {alu_a[3], 4'($signed(alu_a) >>> alu_c)};
            2'b01: alu_ans = {1'b0, alu_a >> alu_c};
            2'b10: alu_ans = {1'b0, alu_a} - {1'b0, alu_b};
            default: alu_ans = {1'b0, alu_a} + {1'b0, alu_b};
        endcase
    end

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sendNib(input logic [3:0] n);
        in_valid = 1'b1;
        in_data  = n;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic checkResetState(input string tag);
        checkEq({tag, "_in_ready"},  32'(in_ready),  32'd1);
        checkEq({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        checkEq({tag, "_out_data"},  32'(out_data),  32'd0);
        checkEq({tag, "_out_op"},    32'(out_op),    32'd0);
        checkEq({tag, "_cmd_count"}, 32'(cmd_count), 32'd0);
        checkEq({tag, "_abort"},     32'(abort),     32'd0);
        checkEq({tag, "_alu_in"},    32'({alu_a, alu_b, alu_c, alu_op}), 32'd0);
    endtask

    initial begin
        int lastValidCycle;
        logic [3:0] a;
        logic [3:0] b;

        reset     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        checkResetState("rst");

        // ADD 7+9 = 16
        sendNib(4'hC);
        sendNib(4'h7);
        sendNib(4'h9);
        checkEq("add_exec_valid", 32'(out_valid), 32'd0);
        checkEq("add_exec_ready", 32'(in_ready),  32'd0);
        tick();
        checkEq("add_valid", 32'(out_valid), 32'd1);
        checkEq("add_data",  32'(out_data),  32'h10);
        checkEq("add_op",    32'(out_op),    32'd3);
        checkEq("add_count", 32'(cmd_count), 32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkEq("add_accept_valid", 32'(out_valid), 32'd0);
        checkEq("add_accept_ready", 32'(in_ready),  32'd1);

        // SUB 3-5 = -2, downstream stalls with in_valid pulses during HOLD
        sendNib(4'h8);
        sendNib(4'h3);
        sendNib(4'h5);
        tick();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 4'hF;
            tick();
            checkEq("sub_hold_valid", 32'(out_valid), 32'd1);
            checkEq("sub_hold_data",  32'(out_data),  32'h1E);
            checkEq("sub_hold_ready", 32'(in_ready),  32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkEq("sub_accept_valid", 32'(out_valid), 32'd0);
        checkEq("sub_regs_kept", 32'({alu_a, alu_b, alu_op}), 32'({4'h3, 4'h5, 2'b10}));
        checkEq("sub_count", 32'(cmd_count), 32'd2);

        // SRL c=2 of 12 = 3, two nibbles only
        sendNib(4'h6);
        checkEq("srl_b_zero", 32'(alu_b),  32'd0);
        checkEq("srl_c",      32'(alu_c),  32'd2);
        checkEq("srl_op",     32'(alu_op), 32'd1);
        sendNib(4'hC);
        in_valid = 1'b1;
        in_data  = 4'h5;
        tick();
        checkEq("srl_valid", 32'(out_valid), 32'd1);
        checkEq("srl_data",  32'(out_data),  32'h03);
        checkEq("srl_op_tag", 32'(out_op),   32'd1);
        checkEq("srl_no_third", 32'({alu_a, alu_b}), 32'({4'hC, 4'h0}));
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkEq("srl_count", 32'(cmd_count), 32'd3);

        // Idle timeout in GET_B
        sendNib(4'hC);
        sendNib(4'h1);
        for (int i = 0; i < 14; i++) tick();
        checkEq("to_before_abort", 32'(abort),    32'd0);
        checkEq("to_before_ready", 32'(in_ready), 32'd1);
        checkEq("to_before_a",     32'(alu_a),    32'd1);
        tick();
        checkEq("to_abort",     32'(abort),     32'd1);
        checkEq("to_alu_zero",  32'({alu_a, alu_b, alu_c, alu_op}), 32'd0);
        checkEq("to_count",     32'(cmd_count), 32'd3);
        checkEq("to_ready",     32'(in_ready),  32'd1);
        tick();
        checkEq("to_abort_pulse", 32'(abort), 32'd0);
        sendNib(4'hC);
        sendNib(4'h2);
        sendNib(4'h3);
        tick();
        checkEq("to_next_data",  32'(out_data),  32'h05);
        checkEq("to_next_count", 32'(cmd_count), 32'd4);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset while waiting for B
        sendNib(4'hF);
        sendNib(4'h1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        checkResetState("midrst");
        tick();
        checkEq("midrst_abort", 32'(abort), 32'd0);
        sendNib(4'hF);
        sendNib(4'h1);
        sendNib(4'h1);
        tick();
        checkEq("midrst_data",  32'(out_data),  32'h02);
        checkEq("midrst_count", 32'(cmd_count), 32'd1);
        out_ready = 1'b1;
        tick();

        // 256 back-to-back ADDs, count wraps to 0
        reset = 1'b0;
        tick();
        reset = 1'b1;
        lastValidCycle = 0;
        for (int i = 0; i < 256; i++) begin
            a = 4'(i);
            b = 4'(i * 7 + 3);
            sendNib(4'hC);
            sendNib(a);
            sendNib(b);
            tick();
            checkEq("b2b_valid", 32'(out_valid), 32'd1);
            checkEq("b2b_data",  32'(out_data),  32'({1'b0, a} + {1'b0, b}));
            if (i > 0) checkEq("b2b_period", 32'(cycle - lastValidCycle), 32'd5);
            lastValidCycle = cycle;
            if (i == 254) checkEq("b2b_count_254", 32'(cmd_count), 32'd255);
            tick();
        end
        checkEq("b2b_wrap",  32'(cmd_count), 32'd0);
        checkEq("b2b_ready", 32'(in_ready),  32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
